// File: rtl/cardinal_port_arbiter_if.sv
// Handshake bundle for cardinal_port_arbiter: requester heads in,
// one registered output channel out, plus the shared phase bit.
//   master : arbiter side (drives req_ready, out_*, polarity)
//   slave  : requesters + downstream side
interface cardinal_port_arbiter_if #(
    parameter int N_REQ  = 3,
    parameter int DATA_W = 64
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    out_valid;
    logic [DATA_W-1:0]       out_data;
    logic                    out_ready;
    logic                    polarity;

    modport master (
        input  req_valid,
        input  req_data,
        input  out_ready,
        output req_ready,
        output out_valid,
        output out_data,
        output polarity
    );

    modport slave (
        output req_valid,
        output req_data,
        output out_ready,
        input  req_ready,
        input  out_valid,
        input  out_data,
        input  polarity
    );
endinterface

// File: rtl/cardinal_port_arbiter.sv
// Output-port arbiter for the cardinal ring router: polarity-gated
// round-robin grant into a one-entry valid/ready output register.
// Ports: clk, reset (sync, active-high), bus (master modport):
//   req_valid/req_data in, req_ready out (one-hot, combinational),
//   out_valid/out_data out, out_ready in, polarity out.
// Build option: CARDINAL_ARB_FIXED_PRIO_EN selects fixed priority
//   (lowest eligible index wins, no round-robin pointer).
module cardinal_port_arbiter #(
    parameter int N_REQ  = 3,
    parameter int DATA_W = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    cardinal_port_arbiter_if.master bus
);

    typedef enum logic {
        S_EMPTY,
        S_FULL
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_pol;
    logic [DATA_W-1:0]   r_data;

    logic [N_REQ-1:0]    w_elig;
    logic [N_REQ-1:0]    w_cand;
    logic [N_REQ-1:0]    w_pick;
    logic [N_REQ-1:0]    w_grant;
    logic [DATA_W-1:0]   w_gdata;
    logic                w_space;
    logic                w_allow;
    logic                w_fire;

    // A packet may leave its buffer only in the phase matching its VC bit.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_elig[i] = bus.req_valid[i] &
                        (bus.req_data[i*DATA_W] == r_pol);
        end
    end

    assign w_space = (r_state == S_EMPTY) | bus.out_ready;
    assign w_allow = w_space & ~reset;

`ifdef CARDINAL_ARB_FIXED_PRIO_EN

    assign w_cand = w_elig;

`else

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0]    r_ptr;
    logic [PTR_W-1:0]    w_gidx;
    logic [N_REQ-1:0]    w_hi;

    // Requesters at or above the pointer get first pick; if none of
    // them is eligible the search wraps to the low indices.
    always_comb begin
        w_hi = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_hi[i] = w_elig[i] & (PTR_W'(i) >= r_ptr);
        end
        w_cand = (|w_hi) ? w_hi : w_elig;
    end

    always_comb begin
        w_gidx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_pick[i]) begin
                w_gidx = PTR_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_fire) begin
            r_ptr <= (w_gidx == PTR_W'(N_REQ - 1)) ?
                     '0 : w_gidx + 1'b1;
        end
    end

`endif

    // Lowest set bit of the candidate vector.
    always_comb begin
        w_pick = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_cand[i]) begin
                w_pick    = '0;
                w_pick[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_gdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_pick[i]) begin
                w_gdata = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_fire  = w_allow & (|w_elig);
    assign w_grant = w_allow ? w_pick : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A drain with a simultaneous grant keeps the register full.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_EMPTY: begin
                if (w_fire) begin
                    w_state_nxt = S_FULL;
                end
            end
            S_FULL: begin
                if (bus.out_ready & ~w_fire) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= '0;
            r_pol  <= 1'b0;
        end else begin
            r_pol <= ~r_pol;
            if (w_fire) begin
                r_data <= w_gdata;
            end
        end
    end

    assign bus.req_ready = w_grant;
    assign bus.out_valid = (r_state == S_FULL);
    assign bus.out_data  = r_data;
    assign bus.polarity  = r_pol;

endmodule

// File: tb/tb_cardinal_port_arbiter.sv
// Self-checking bench for cardinal_port_arbiter.
// Expected packets are queued at grant time and checked at drain.
module tb_cardinal_port_arbiter;

    localparam int N = 3;
    localparam int W = 64;

`ifdef CARDINAL_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    cardinal_port_arbiter_if #(.N_REQ(N), .DATA_W(W)) bus ();

    cardinal_port_arbiter #(
        .N_REQ  (N),
        .DATA_W (W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int         n_run  = 0;
    int         n_fail = 0;
    logic       exp_pol;
    logic [W-1:0] d [N];
    logic [W-1:0] exp_q [$];
    logic [W-1:0] exp_d;
    logic [N-1:0] exp_g;
    int         e;

    function automatic logic [W-1:0] mk(input int c, input int i,
                                        input logic vc);
        return {16'hC0DE, 8'(c), 8'(i), 31'h1234567, vc};
    endfunction

    task automatic tick();
        logic was;
        was = reset;
        @(posedge clk);
        exp_pol = was ? 1'b0 : ~exp_pol;
        #1;
    endtask

    task automatic drive(input logic [N-1:0] v);
        bus.req_valid = v;
        bus.req_data  = {d[2], d[1], d[0]};
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus.out_ready = 1'b0;
        for (int i = 0; i < N; i++) d[i] = mk(0, i, 1'b0);
        drive(3'b111);
        tick(); tick(); tick();
        #1;
        n_run++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_valid: got %b want 0", bus.out_valid);
        end
        n_run++;
        if (bus.out_data !== 64'h0) begin
            n_fail++;
            $display("FAIL rst_data: got %h want 0", bus.out_data);
        end
        n_run++;
        if (bus.polarity !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_pol: got %b want 0", bus.polarity);
        end
        n_run++;
        if (bus.req_ready !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_ready: got %b want 000", bus.req_ready);
        end
        drive(3'b000);
        reset = 1'b0;
    endtask

    task automatic test_single();
        d[0] = 64'hA5A5_A5A5_A5A5_A5A4;
        drive(3'b001);
        bus.out_ready = 1'b1;
        #1;
        n_run++;
        if (bus.req_ready !== 3'b001) begin
            n_fail++;
            $display("FAIL single_grant: got %b want 001", bus.req_ready);
        end
        exp_q.push_back(d[0]);
        tick();
        drive(3'b000);
        #1;
        n_run++;
        if (bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL single_valid: got %b want 1", bus.out_valid);
        end
        exp_d = exp_q.pop_front();
        n_run++;
        if (bus.out_data !== exp_d) begin
            n_fail++;
            $display("FAIL single_data: got %h want %h", bus.out_data, exp_d);
        end
        tick();
        #1;
        n_run++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_empty: got %b want 0", bus.out_valid);
        end
    endtask

    task automatic test_polarity();
        if (exp_pol) begin
            drive(3'b000);
            tick();
        end
        d[1] = 64'h1234_5678_9ABC_DEF1;
        drive(3'b010);
        bus.out_ready = 1'b1;
        #1;
        n_run++;
        if (bus.req_ready !== 3'b000 || bus.polarity !== 1'b0) begin
            n_fail++;
            $display("FAIL pol_gate: got rdy=%b pol=%b want 000/0",
                     bus.req_ready, bus.polarity);
        end
        tick();
        #1;
        n_run++;
        if (bus.req_ready !== 3'b010 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL pol_grant: got rdy=%b vld=%b want 010/0",
                     bus.req_ready, bus.out_valid);
        end
        exp_q.push_back(d[1]);
        tick();
        drive(3'b000);
        #1;
        exp_d = exp_q.pop_front();
        n_run++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== exp_d) begin
            n_fail++;
            $display("FAIL pol_out: got %b/%h want 1/%h",
                     bus.out_valid, bus.out_data, exp_d);
        end
        tick();
    endtask

    task automatic test_wrap();
        for (int i = 0; i < N; i++) d[i] = mk(1, i, exp_pol);
        d[2][0] = ~exp_pol;
        drive(3'b111);
        bus.out_ready = 1'b1;
        #1;
        n_run++;
        if (bus.req_ready !== 3'b001) begin
            n_fail++;
            $display("FAIL wrap_grant: got %b want 001", bus.req_ready);
        end
        exp_q.push_back(d[0]);
        tick();
        for (int i = 0; i < N; i++) d[i] = mk(2, i, exp_pol);
        d[2][0] = ~exp_pol;
        drive(3'b111);
        #1;
        exp_d = exp_q.pop_front();
        n_run++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== exp_d) begin
            n_fail++;
            $display("FAIL wrap_out0: got %b/%h want 1/%h",
                     bus.out_valid, bus.out_data, exp_d);
        end
        e     = FIXED ? 0 : 1;
        exp_g = 3'b001 << e;
        n_run++;
        if (bus.req_ready !== exp_g) begin
            n_fail++;
            $display("FAIL wrap_b2b: got %b want %b", bus.req_ready, exp_g);
        end
        exp_q.push_back(d[e]);
        tick();
        drive(3'b000);
        #1;
        exp_d = exp_q.pop_front();
        n_run++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== exp_d) begin
            n_fail++;
            $display("FAIL wrap_out1: got %b/%h want 1/%h",
                     bus.out_valid, bus.out_data, exp_d);
        end
        tick();
        #1;
        n_run++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_empty: got %b want 0", bus.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        d[1] = mk(3, 1, exp_pol);
        drive(3'b010);
        bus.out_ready = 1'b0;
        #1;
        exp_q.push_back(d[1]);
        tick();
        drive(3'b000);
        #1;
        n_run++;
        if (bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_full: got %b want 1", bus.out_valid);
        end
        reset = 1'b1;
        for (int i = 0; i < N; i++) d[i] = mk(4, i, exp_pol);
        drive(3'b111);
        #1;
        n_run++;
        if (bus.req_ready !== 3'b000) begin
            n_fail++;
            $display("FAIL rmid_nogrant: got %b want 000", bus.req_ready);
        end
        exp_q.delete();
        tick();
        reset = 1'b0;
        for (int i = 0; i < N; i++) d[i] = mk(5, i, 1'b0);
        drive(3'b111);
        bus.out_ready = 1'b1;
        #1;
        n_run++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 64'h0 ||
            bus.polarity !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_state: got %b/%h/%b want 0/0/0",
                     bus.out_valid, bus.out_data, bus.polarity);
        end
        n_run++;
        if (bus.req_ready !== 3'b001) begin
            n_fail++;
            $display("FAIL rmid_grant: got %b want 001", bus.req_ready);
        end
        exp_q.push_back(d[0]);
        tick();
        drive(3'b000);
        #1;
        exp_d = exp_q.pop_front();
        n_run++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== exp_d) begin
            n_fail++;
            $display("FAIL rmid_out: got %b/%h want 1/%h",
                     bus.out_valid, bus.out_data, exp_d);
        end
        tick();
    endtask

    task automatic test_round_robin();
        reset = 1'b1;
        drive(3'b000);
        tick();
        reset         = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < N; i++) d[i] = mk(10 + c, i, exp_pol);
            drive(3'b111);
            #1;
            e     = FIXED ? 0 : c % 3;
            exp_g = 3'b001 << e;
            n_run++;
            if (bus.req_ready !== exp_g) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: got %b want %b",
                         c, bus.req_ready, exp_g);
            end
            if (c > 0) begin
                exp_d = exp_q.pop_front();
                n_run++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== exp_d) begin
                    n_fail++;
                    $display("FAIL rr_out[%0d]: got %b/%h want 1/%h",
                             c, bus.out_valid, bus.out_data, exp_d);
                end
            end
            exp_q.push_back(d[e]);
            tick();
        end
        drive(3'b000);
        #1;
        exp_d = exp_q.pop_front();
        n_run++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== exp_d) begin
            n_fail++;
            $display("FAIL rr_last: got %b/%h want 1/%h",
                     bus.out_valid, bus.out_data, exp_d);
        end
        tick();
    endtask

    task automatic test_backpressure();
        d[0] = mk(20, 0, exp_pol);
        drive(3'b001);
        bus.out_ready = 1'b0;
        #1;
        n_run++;
        if (bus.req_ready !== 3'b001) begin
            n_fail++;
            $display("FAIL bp_load: got %b want 001", bus.req_ready);
        end
        exp_q.push_back(d[0]);
        tick();
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < N; i++) d[i] = mk(21 + k, i, exp_pol);
            drive(3'b111);
            #1;
            n_run++;
            if (bus.req_ready !== 3'b000 || bus.out_valid !== 1'b1 ||
                bus.out_data !== exp_q[0]) begin
                n_fail++;
                $display("FAIL bp_stall[%0d]: got %b/%b/%h want 000/1/%h",
                         k, bus.req_ready, bus.out_valid,
                         bus.out_data, exp_q[0]);
            end
            tick();
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < N; i++) d[i] = mk(30, i, exp_pol);
        drive(3'b111);
        #1;
        e     = FIXED ? 0 : 1;
        exp_g = 3'b001 << e;
        n_run++;
        if (bus.req_ready !== exp_g) begin
            n_fail++;
            $display("FAIL bp_regrant: got %b want %b", bus.req_ready, exp_g);
        end
        exp_d = exp_q.pop_front();
        n_run++;
        if (bus.out_data !== exp_d) begin
            n_fail++;
            $display("FAIL bp_drain: got %h want %h", bus.out_data, exp_d);
        end
        exp_q.push_back(d[e]);
        tick();
        drive(3'b000);
        #1;
        exp_d = exp_q.pop_front();
        n_run++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== exp_d) begin
            n_fail++;
            $display("FAIL bp_b2b: got %b/%h want 1/%h",
                     bus.out_valid, bus.out_data, exp_d);
        end
        tick();
        #1;
        n_run++;
        if (bus.out_valid !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_end: got vld=%b q=%0d want 0/0",
                     bus.out_valid, exp_q.size());
        end
    endtask

    initial begin
        exp_pol       = 1'b0;
        reset         = 1'b1;
        bus.out_ready = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        test_reset();
        test_single();
        test_polarity();
        test_wrap();
        test_reset_mid();
        test_round_robin();
        test_backpressure();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule
